lsu_txn_monitor: RTL and testbench

Parametrised passive monitor for the LSU data-memory interface: observes the req/gnt/rvalid bus and pairs each granted request with its response through an in-order outstanding-transaction queue. For each completed transaction it emits one registered record (type, address, byte-enables, masked data, error, latency). Keeps saturating load/store/error counters and checks bus protocol rules, latching the first violation. Instantiated beside the LSU in testbenches and formal harnesses; drives nothing back into the design.

---
 rtl/lsu_mon_pkg.sv | 21 ++
 rtl/lsu_mon_fifo.sv | 68 ++++++
 rtl/lsu_txn_monitor.sv | 173 +++++++++++++++++
 tb/tb_lsu_txn_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mon_pkg.sv
// Shared types and helpers for the LSU transaction monitor: protocol-violation
// codes and a width-generic saturating increment.
package lsu_mon_pkg;

  typedef enum logic [2:0] {
    NONE          = 3'd0,
    RVALID_NO_TXN = 3'd1,
    PUSH_WHEN_FULL = 3'd2,
    REQ_UNSTABLE  = 3'd3,
    HEAD_TIMEOUT  = 3'd4,
    GNT_NO_REQ    = 3'd5
  } proto_err_e;

  // Increments value unless it already holds the all-ones pattern of 'width' bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/lsu_mon_fifo.sv
// In-order outstanding-transaction queue with per-slot saturating age counters.
// A pop and a push in the same cycle are accepted even when full.
module lsu_mon_fifo #(
  parameter int unsigned Depth    = 2,
  parameter int unsigned Width    = 8,
  parameter int unsigned AgeWidth = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           push_data,
  output logic [Width-1:0]           head_data,
  output logic [AgeWidth-1:0]        head_age,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Width-1:0]    mem [Depth];
  logic [AgeWidth-1:0] age [Depth];
  logic [PtrWidth-1:0] rd_ptr, wr_ptr;
  logic                do_push, do_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full      = (count == CntWidth'(Depth));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];
  assign head_age  = age[rd_ptr];

  // When full, wr_ptr equals rd_ptr, so a simultaneous push reuses the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
        age[i] <= '0;
      end
    end else begin
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
      for (int i = 0; i < int'(Depth); i++) begin
        if (do_push && wr_ptr == PtrWidth'(i)) age[i] <= '0;
        else if (age[i] != '1)                 age[i] <= age[i] + AgeWidth'(1);
      end
    end
  end

endmodule

// File: rtl/lsu_txn_monitor.sv
// Passive LSU data-bus monitor: pairs grants with responses, emits one record per
// completed transaction, keeps statistics and latches the first protocol violation.
module lsu_txn_monitor
  import lsu_mon_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned LatWidth       = 8,
  parameter int unsigned TimeoutCycles  = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                data_req_i,
  input  logic                                data_gnt_i,
  input  logic                                data_we_i,
  input  logic [AddrWidth-1:0]                data_addr_i,
  input  logic [DataWidth/8-1:0]              data_be_i,
  input  logic [DataWidth-1:0]                data_wdata_i,
  input  logic                                data_rvalid_i,
  input  logic [DataWidth-1:0]                data_rdata_i,
  input  logic                                data_err_i,
  output logic                                txn_valid_o,
  output logic                                txn_we_o,
  output logic [AddrWidth-1:0]                txn_addr_o,
  output logic [DataWidth/8-1:0]              txn_be_o,
  output logic [DataWidth-1:0]                txn_data_o,
  output logic                                txn_err_o,
  output logic [LatWidth-1:0]                 txn_lat_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic [CntWidth-1:0]                 n_loads_o,
  output logic [CntWidth-1:0]                 n_stores_o,
  output logic [CntWidth-1:0]                 n_errs_o,
  output logic                                proto_err_o,
  output logic [2:0]                          proto_err_code_o
);

  localparam int unsigned BeWidth      = DataWidth / 8;
  localparam int unsigned TimeoutWidth = $clog2(TimeoutCycles + 1);
  localparam int unsigned AgeWidth     = (LatWidth > TimeoutWidth) ? LatWidth : TimeoutWidth;
  localparam logic [AgeWidth:0] LatMax = {{(AgeWidth + 1 - LatWidth){1'b0}}, {LatWidth{1'b1}}};

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

  entry_t                push_entry, head;
  logic [EntryWidth-1:0] head_raw;
  logic [AgeWidth-1:0]   head_age;
  logic [AgeWidth:0]     lat_ext;
  logic [LatWidth-1:0]   lat;
  logic [DataWidth-1:0]  raw_data, masked_data;
  logic                  fifo_full, fifo_empty, push_req, pop, req_unstable;
  logic                  prev_stall, prev_we;
  logic [AddrWidth-1:0]  prev_addr;
  logic [BeWidth-1:0]    prev_be;
  logic [DataWidth-1:0]  prev_wdata;
  proto_err_e            viol;

  assign push_req   = data_req_i & data_gnt_i;
  assign pop        = data_rvalid_i & ~fifo_empty;
  assign push_entry = '{we: data_we_i, addr: data_addr_i, be: data_be_i, wdata: data_wdata_i};
  assign head       = head_raw;

  lsu_mon_fifo #(
    .Depth    (MaxOutstanding),
    .Width    (EntryWidth),
    .AgeWidth (AgeWidth)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push_req),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_raw),
    .head_age  (head_age),
    .count     (outstanding_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head age counts from the cycle after the grant, so latency is one more than age.
  assign lat_ext = {1'b0, head_age} + (AgeWidth + 1)'(1);
  assign lat     = (lat_ext > LatMax) ? LatMax[LatWidth-1:0] : lat_ext[LatWidth-1:0];

  always_comb begin
    raw_data    = head.we ? head.wdata : data_rdata_i;
    masked_data = '0;
    for (int b = 0; b < int'(BeWidth); b++)
      masked_data[b*8 +: 8] = raw_data[b*8 +: 8] & {8{head.be[b]}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txn_valid_o <= 1'b0;
      txn_we_o    <= 1'b0;
      txn_addr_o  <= '0;
      txn_be_o    <= '0;
      txn_data_o  <= '0;
      txn_err_o   <= 1'b0;
      txn_lat_o   <= '0;
    end else begin
      txn_valid_o <= pop;
      if (pop) begin
        txn_we_o   <= head.we;
        txn_addr_o <= head.addr;
        txn_be_o   <= head.be;
        txn_data_o <= masked_data;
        txn_err_o  <= data_err_i;
        txn_lat_o  <= lat;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_loads_o  <= '0;
      n_stores_o <= '0;
      n_errs_o   <= '0;
    end else if (pop) begin
      if (head.we) n_stores_o <= CntWidth'(sat_inc(64'(n_stores_o), CntWidth));
      else         n_loads_o  <= CntWidth'(sat_inc(64'(n_loads_o), CntWidth));
      if (data_err_i) n_errs_o <= CntWidth'(sat_inc(64'(n_errs_o), CntWidth));
    end
  end

  // Snapshot of a stalled request, used to check that it stays stable until granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_stall <= 1'b0;
      prev_we    <= 1'b0;
      prev_addr  <= '0;
      prev_be    <= '0;
      prev_wdata <= '0;
    end else begin
      prev_stall <= data_req_i & ~data_gnt_i;
      prev_we    <= data_we_i;
      prev_addr  <= data_addr_i;
      prev_be    <= data_be_i;
      prev_wdata <= data_wdata_i;
    end
  end

  assign req_unstable = prev_stall &&
                        (!data_req_i || data_we_i != prev_we || data_addr_i != prev_addr ||
                         data_be_i != prev_be || (prev_we && data_wdata_i != prev_wdata));

  always_comb begin
    viol = NONE;
    if (data_rvalid_i && fifo_empty)                  viol = RVALID_NO_TXN;
    else if (push_req && fifo_full && !pop)           viol = PUSH_WHEN_FULL;
    else if (req_unstable)                            viol = REQ_UNSTABLE;
    else if (!fifo_empty && head_age >= AgeWidth'(TimeoutCycles)) viol = HEAD_TIMEOUT;
    else if (data_gnt_i && !data_req_i)               viol = GNT_NO_REQ;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_o      <= 1'b0;
      proto_err_code_o <= '0;
    end else if (!proto_err_o && viol != NONE) begin
      proto_err_o      <= 1'b1;
      proto_err_code_o <= viol;
    end
  end

endmodule

// File: tb/tb_lsu_txn_monitor.sv
// Self-checking bench for lsu_txn_monitor: table-driven vectors plus hand-written
// corner sequences, with a transaction scoreboard for the emitted records.
module tb_lsu_txn_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  logic        txn_valid, txn_we, txn_err, proto_err;
  logic [31:0] txn_addr, txn_data, n_loads, n_stores, n_errs;
  logic [3:0]  txn_be;
  logic [7:0]  txn_lat;
  logic [1:0]  outstanding;
  logic [2:0]  proto_code;

  always #5 clk = ~clk;

  lsu_txn_monitor dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .data_req_i       (req),
    .data_gnt_i       (gnt),
    .data_we_i        (we),
    .data_addr_i      (addr),
    .data_be_i        (be),
    .data_wdata_i     (wdata),
    .data_rvalid_i    (rvalid),
    .data_rdata_i     (rdata),
    .data_err_i       (err),
    .txn_valid_o      (txn_valid),
    .txn_we_o         (txn_we),
    .txn_addr_o       (txn_addr),
    .txn_be_o         (txn_be),
    .txn_data_o       (txn_data),
    .txn_err_o        (txn_err),
    .txn_lat_o        (txn_lat),
    .outstanding_o    (outstanding),
    .n_loads_o        (n_loads),
    .n_stores_o       (n_stores),
    .n_errs_o         (n_errs),
    .proto_err_o      (proto_err),
    .proto_err_code_o (proto_code)
  );

  typedef struct {
    logic        req, gnt, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } stim_t;

  typedef struct {
    stim_t s;
    int    exp_occ;
    logic  exp_valid;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stamp;
  } pend_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
    logic [7:0]  lat;
  } rec_t;

  pend_t pend_q[$];
  rec_t  exp_q[$];
  vec_t  tbl[$];
  int    checks = 0, errors = 0, cyc = 0;
  int    m_loads = 0, m_stores = 0, m_errs = 0;

  function automatic stim_t mk(logic r, logic g, logic w, logic [31:0] a, logic [3:0] b,
                               logic [31:0] wd, logic rv, logic [31:0] rd, logic e);
    stim_t s;
    s.req = r; s.gnt = g; s.we = w; s.addr = a; s.be = b; s.wdata = wd;
    s.rvalid = rv; s.rdata = rd; s.err = e;
    return s;
  endfunction

  function automatic logic [31:0] mask_data(logic [31:0] d, logic [3:0] b);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (b[i]) m[i*8 +: 8] = d[i*8 +: 8];
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of bus activity and advances the reference model.
  task automatic applyStimulus(input stim_t s);
    pend_t p;
    rec_t  r;
    int    lat;
    req = s.req; gnt = s.gnt; we = s.we; addr = s.addr; be = s.be; wdata = s.wdata;
    rvalid = s.rvalid; rdata = s.rdata; err = s.err;
    if (s.rvalid && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      lat = cyc - p.stamp;
      r.we = p.we; r.addr = p.addr; r.be = p.be; r.err = s.err;
      r.data = mask_data(p.we ? p.wdata : s.rdata, p.be);
      r.lat = (lat > 255) ? 8'd255 : 8'(lat);
      exp_q.push_back(r);
      if (p.we) m_stores++; else m_loads++;
      if (s.err) m_errs++;
    end
    if (s.req && s.gnt && pend_q.size() < 2)
      pend_q.push_back('{we: s.we, addr: s.addr, be: s.be, wdata: s.wdata, stamp: cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check({tag, "/valid"}, txn_valid, 1);
      if (txn_valid) begin
        check({tag, "/we"},   txn_we,   r.we);
        check({tag, "/addr"}, txn_addr, r.addr);
        check({tag, "/be"},   txn_be,   r.be);
        check({tag, "/data"}, txn_data, r.data);
        check({tag, "/err"},  txn_err,  r.err);
        check({tag, "/lat"},  txn_lat,  r.lat);
      end
    end else begin
      check({tag, "/valid"}, txn_valid, 0);
    end
    check({tag, "/outstanding"}, outstanding, pend_q.size());
    check({tag, "/n_loads"},  n_loads,  m_loads);
    check({tag, "/n_stores"}, n_stores, m_stores);
    check({tag, "/n_errs"},   n_errs,   m_errs);
  endtask

  task automatic checkProto(input string tag, input logic exp_err, input logic [2:0] exp_code);
    check({tag, "/proto_err"},  proto_err,  exp_err);
    check({tag, "/proto_code"}, proto_code, exp_code);
  endtask

  // Asserts reset between clock edges and verifies every output clears asynchronously.
  task automatic doReset(input string tag);
    req = 0; gnt = 0; we = 0; addr = '0; be = '0; wdata = '0; rvalid = 0; rdata = '0; err = 0;
    rst_n = 1'b0;
    pend_q.delete();
    exp_q.delete();
    m_loads = 0; m_stores = 0; m_errs = 0;
    #1;
    check({tag, "/rst_valid"}, txn_valid, 0);
    check({tag, "/rst_we"}, txn_we, 0);
    check({tag, "/rst_addr"}, txn_addr, 0);
    check({tag, "/rst_be"}, txn_be, 0);
    check({tag, "/rst_data"}, txn_data, 0);
    check({tag, "/rst_err"}, txn_err, 0);
    check({tag, "/rst_lat"}, txn_lat, 0);
    check({tag, "/rst_outstanding"}, outstanding, 0);
    check({tag, "/rst_loads"}, n_loads, 0);
    check({tag, "/rst_stores"}, n_stores, 0);
    check({tag, "/rst_errs"}, n_errs, 0);
    check({tag, "/rst_proto"}, proto_err, 0);
    check({tag, "/rst_code"}, proto_code, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    int    seen;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load, store, then a full-queue pipelined burst with a grant on the first response.
    tbl.push_back('{mk(1, 1, 0, 32'h100, 4'hF, 0, 0, 0, 0), 1, 1'b0});
    tbl.push_back('{idle, 1, 1'b0});
    tbl.push_back('{idle, 1, 1'b0});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0), 0, 1'b1});
    tbl.push_back('{mk(1, 1, 1, 32'h204, 4'b0011, 32'h12345678, 0, 0, 0), 1, 1'b0});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0), 0, 1'b1});
    tbl.push_back('{mk(1, 1, 0, 32'h300, 4'hF, 0, 0, 0, 0), 1, 1'b0});
    tbl.push_back('{mk(1, 1, 1, 32'h304, 4'hF, 32'hCAFEF00D, 0, 0, 0), 2, 1'b0});
    tbl.push_back('{mk(1, 1, 0, 32'h308, 4'b1100, 0, 1, 32'h11112222, 0), 2, 1'b1});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'h99999999, 0), 1, 1'b1});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'hAABBCCDD, 0), 0, 1'b1});
    tbl.push_back('{idle, 0, 1'b0});

    rst_n = 1'b1;
    req = 0; gnt = 0; we = 0; addr = '0; be = '0; wdata = '0; rvalid = 0; rdata = '0; err = 0;
    #2;
    doReset("init");

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(tbl[i].s);
      check({tag, "/tbl_valid"}, txn_valid, tbl[i].exp_valid);
      check({tag, "/tbl_occ"}, outstanding, tbl[i].exp_occ);
      checkOutput(tag);
      checkProto(tag, 0, 0);
    end
    check("table/total_loads", n_loads, 3);
    check("table/total_stores", n_stores, 2);

    // rvalid on an empty queue, then a later timeout must not overwrite code 1.
    doReset("empty_rvalid");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0));
    checkOutput("empty_rvalid");
    checkProto("empty_rvalid", 1, 1);
    applyStimulus(mk(1, 1, 0, 32'h400, 4'hF, 0, 0, 0, 0));
    for (int k = 0; k < 280; k++) applyStimulus(idle);
    checkOutput("sticky");
    checkProto("sticky", 1, 1);

    // Stalled request whose address changes before the grant.
    doReset("unstable");
    applyStimulus(mk(1, 0, 0, 32'h100, 4'hF, 0, 0, 0, 0));
    checkProto("unstable_hold", 0, 0);
    applyStimulus(mk(1, 0, 0, 32'h104, 4'hF, 0, 0, 0, 0));
    checkProto("unstable", 1, 3);

    // Head timeout: flag appears exactly 257 idle cycles after the grant cycle.
    doReset("timeout");
    applyStimulus(mk(1, 1, 0, 32'h800, 4'hF, 0, 0, 0, 0));
    seen = -1;
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(idle);
      if (proto_err && seen < 0) begin
        seen = k;
        break;
      end
    end
    check("timeout/cycle", seen, 257);
    checkProto("timeout", 1, 4);

    // Simultaneous gnt-without-req and empty rvalid: lowest code wins.
    doReset("priority");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));
    checkProto("priority", 1, 1);
    doReset("gnt_no_req");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkProto("gnt_no_req", 1, 5);

    // Third grant on a full queue with no response is dropped.
    doReset("push_full");
    applyStimulus(mk(1, 1, 0, 32'h600, 4'hF, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 1, 32'h604, 4'b0110, 32'hA1B2C3D4, 0, 0, 0));
    applyStimulus(mk(1, 1, 0, 32'h608, 4'hF, 0, 0, 0, 0));
    checkOutput("push_full");
    checkProto("push_full", 1, 2);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
    checkOutput("push_full_r0");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
    checkOutput("push_full_r1");

    // Error response, then reset with one entry outstanding.
    doReset("err");
    applyStimulus(mk(1, 1, 0, 32'h500, 4'hF, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 32'h00000055, 1));
    checkOutput("err_resp");
    check("err_resp/n_errs_one", n_errs, 1);
    applyStimulus(mk(1, 1, 0, 32'h504, 4'hF, 0, 0, 0, 0));
    checkOutput("err_pending");
    doReset("mid_reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(idle);
      checkOutput($sformatf("post_reset%0d", k));
    end
    checkProto("post_reset", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
